// File: rtl/bin2bcd_sequencer_if.sv
// Handshake bundle for bin2bcd_sequencer.
//   master: the binary producer and BCD consumer side (drives in_valid, bin_in, out_ready)
//   slave : the converter (drives in_ready, out_valid, bcd_out, busy)
interface bin2bcd_sequencer_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      bin_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  busy;

  modport master (
    output in_valid, bin_in, out_ready,
    input  in_ready, out_valid, bcd_out, busy
  );

  modport slave (
    input  in_valid, bin_in, out_ready,
    output in_ready, out_valid, bcd_out, busy
  );
endinterface

// File: rtl/bin2bcd_sequencer.sv
// Serial double-dabble converter: accepts one unsigned WIDTH-bit word, runs
// WIDTH adjust/shift iterations, then presents DIGITS packed BCD digits.
// Ports:
//   clk  - rising-edge clock
//   rstn - asynchronous active-low reset
//   bus  - slave side of bin2bcd_sequencer_if
//          in_valid/in_ready/bin_in    : input word handshake (ready only in IDLE)
//          out_valid/out_ready/bcd_out : result handshake (valid only in DONE)
//          busy                        : conversion in progress
module bin2bcd_sequencer #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rstn,
  bin2bcd_sequencer_if.slave    bus
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADJUST = 2'd1,
    SHIFT  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   bin_sr;
  logic [BCD_W-1:0]   bcd_sr;
  logic [BCD_W-1:0]   bcd_adj;
  logic [CNT_W-1:0]   cnt;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               busy_q;

  // Add-3 correction, every nibble from its pre-adjust value; max result 12 so no carry.
  always_comb begin
    bcd_adj = bcd_sr;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (bcd_sr[4*d +: 4] >= 4'd5) begin
        bcd_adj[4*d +: 4] = bcd_sr[4*d +: 4] + 4'd3;
      end
    end
  end

  // Sequencer: state, datapath registers and registered handshake outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      bin_sr      <= '0;
      bcd_sr      <= '0;
      cnt         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // bcd_sr keeps the previous result until a new word arrives.
          if (bus.in_valid) begin
            bin_sr     <= bus.bin_in;
            bcd_sr     <= '0;
            cnt        <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state      <= ADJUST;
          end
        end

        ADJUST: begin
          bcd_sr <= bcd_adj;
          state  <= SHIFT;
        end

        SHIFT: begin
          // {bcd_sr, bin_sr} shifts left as one long register.
          bcd_sr <= {bcd_sr[BCD_W-2:0], bin_sr[WIDTH-1]};
          bin_sr <= {bin_sr[WIDTH-2:0], 1'b0};
          if (cnt == CNT_W'(WIDTH - 1)) begin
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            cnt   <= cnt + CNT_W'(1);
            state <= ADJUST;
          end
        end

        DONE: begin
          // No accept on the handover edge; in_ready rises for the next cycle.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.bcd_out   = bcd_sr;

  // Every output digit must be a legal decimal digit.
  logic digits_legal;
  always_comb begin
    digits_legal = 1'b1;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (bcd_sr[4*d +: 4] > 4'd9) begin
        digits_legal = 1'b0;
      end
    end
  end

  a_digits_legal: assert property (@(posedge clk) disable iff (!rstn)
    out_valid_q |-> digits_legal);

  a_flags_exclusive: assert property (@(posedge clk) disable iff (!rstn)
    !(out_valid_q && (busy_q || in_ready_q)) && !(busy_q && in_ready_q));

endmodule

// File: doc/bin2bcd_sequencer.md
# bin2bcd_sequencer

- Sequences the serial double-dabble conversion of an unsigned binary word into packed BCD digits.
- Takes one binary word per handshake, shifts it MSB-first through a BCD scratch register, and applies add-3 correction before every shift.
- Presents the finished digits with a valid/ready handshake.
- Sits between the binary datapath, which produces the value, and the display/BCD consumers.

## Interface

Parameters:
- WIDTH, 8: binary input width. Supported range is 4..16.
- DIGITS, 3: number of BCD digits. The user must guarantee 10^DIGITS > 2^WIDTH-1. The default pair is 8 / 3.

Ports:
- clk  input  1: single clock; all state updates on the rising edge.
- rstn  input  1: reset, asynchronous and active-low.
- in_valid  input  1: a binary word is offered on bin_in.
- in_ready  output  1: the block can accept a word. High only in IDLE.
- bin_in  input  WIDTH: unsigned binary value, sampled when in_valid && in_ready.
- out_valid  output  1: bcd_out holds a completed conversion. High only in DONE.
- out_ready  input  1: the consumer takes bcd_out.
- bcd_out  output  4*DIGITS: packed BCD, ones in [3:0], tens in [7:4], and so on.
- busy  output  1: high in ADJUST or SHIFT.

## Operation

Storage:
- bin_sr, WIDTH bits: remaining binary bits.
- bcd_sr, 4*DIGITS bits: the scratch register that drives bcd_out.
- cnt: shift counter, counts 0..WIDTH-1.

FSM states and transitions:
- IDLE:
  - If in_valid is high: load bin_sr <= bin_in, clear bcd_sr, cnt <= 0, go to ADJUST.
  - Otherwise stay in IDLE. bcd_sr keeps the last result.
- ADJUST:
  - For every digit nibble n, n <= n+3 if n >= 5, otherwise unchanged.
  - All nibbles are evaluated in parallel from their pre-adjust values.
  - Go to SHIFT.
- SHIFT:
  - Shift {bcd_sr, bin_sr} left by one. The bin_sr MSB enters bcd_sr[0]; bin_sr[0] <= 0.
  - If cnt == WIDTH-1, go to DONE. Otherwise cnt <= cnt+1 and go to ADJUST.
- DONE:
  - out_valid = 1 and bcd_out is stable.
  - If out_ready is high, go to IDLE. Otherwise hold.

Rules and boundary conditions:
- Arithmetic: each nibble after adjust is at most 12, so the add never carries out of its nibble. No nibble ever exceeds 9 at the output.
- in_valid outside IDLE is ignored (in_ready = 0). The upstream side must hold bin_in with in_valid until it is accepted.
- out_ready outside DONE is ignored.
- There is no accept in the DONE-to-IDLE cycle. The next word can be accepted on the first IDLE cycle, so the minimum spacing between accepts is WIDTH*2+2 cycles.
- bin_in = 0 still runs all WIDTH iterations and returns all zeros.
- Maximum input (2^WIDTH-1) must convert exactly. For the defaults, 255 gives 0x255.
- Reset asserted at any time, including mid-conversion or while DONE awaits out_ready: the state immediately goes to IDLE and the partial result is discarded.

Reset values:
- in_ready = 1 (the state is IDLE).
- out_valid = 0, busy = 0, bcd_out = 0, cnt = 0.
- bin_sr = 0.

## Timing

- Accept edge: the edge where in_valid && in_ready is high, called E0.
- Edges E1..E2*WIDTH alternate ADJUST, SHIFT, ADJUST, SHIFT, and so on.
- Latency: out_valid rises after edge E2*WIDTH, which is 16 cycles after acceptance for WIDTH = 8.
- busy is high from after E0 until after E2*WIDTH.
- Handover: the handshake completes on the edge where out_valid && out_ready are both high. out_valid falls after that edge and in_ready rises after the same edge.
- bcd_out is registered (no combinational path from inputs) and is stable throughout DONE.
- Reset deassertion is synchronous to clk at the system level. The first accept is allowed on the first edge after rstn rises.

## Test plan

- Reset, then bin_in = 8'd255 with in_valid held and out_ready = 1 -> out_valid after exactly 16 edges, bcd_out = 12'h255, then in_ready returns.
- Conversions of 0, 9, 10, 99, 100 and 128 -> bcd_out = 12'h000, 12'h009, 12'h010, 12'h099, 12'h100 and 12'h128 respectively, each with 16-cycle latency.
- Exhaustive sweep 0..255 with a random out_ready stall of 0..5 cycles -> every result matches the decimal reference; out_valid and bcd_out stay stable during the stall; no word is lost or duplicated.
- in_valid pulsed with bin_in = 8'd77 while busy (cnt = 3) -> ignored; the in-flight word 8'd200 completes as 12'h200.
- rstn pulled low at cycle 7 of the conversion of 8'd173 -> outputs immediately reset to IDLE values. After release, converting 8'd42 returns 12'h042.
- Back-to-back words 8'd1 and 8'd254 with in_valid held high and out_ready = 1 -> results 12'h001 then 12'h254; accept spacing is 18 cycles.
